// File: rtl/req_encoder_8to3.sv
// 8-to-3 request encoder: captures request strobes into a pending register and
// grants one index at a time on a valid/ready channel, round-robin or fixed priority.
//
// state | meaning
// IDLE  | no grant presented, out_valid=0
// HOLD  | out_idx presented with out_valid=1, waiting for out_ready
module req_encoder_8to3 #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       clear,
  output logic [2:0] out_idx,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] pending,
  output logic       overrun
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pending, w_pending_nxt;
  logic [7:0] w_acc_mask, w_rem;
  logic [2:0] r_out_idx, w_out_idx_nxt;
  logic [2:0] r_rr_ptr, w_rr_ptr_nxt, w_rr_ptr_acc;
  logic       r_overrun, w_overrun_nxt;
  logic       w_accept;

  // First set bit scanning upward from ptr with wrap; fixed mode always scans from 0.
  function automatic logic [2:0] sel(input logic [7:0] vec, input logic [2:0] ptr);
    logic [2:0] base;
    logic [2:0] idx;
    sel  = 3'd0;
    base = ROUND_ROBIN ? ptr : 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = base + 3'(i);
      if (vec[idx]) sel = idx;
    end
  endfunction

  always_comb begin
    w_accept      = (r_state == HOLD) && out_ready;
    w_acc_mask    = w_accept ? (8'd1 << r_out_idx) : 8'd0;
    w_rem         = r_pending & ~w_acc_mask;
    w_rr_ptr_acc  = r_out_idx + 3'd1;

    w_state_nxt   = r_state;
    w_out_idx_nxt = r_out_idx;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_pending_nxt = w_rem | req;
    w_overrun_nxt = r_overrun | (|(req & w_rem));

    if (clear) begin
      w_state_nxt   = IDLE;
      w_rr_ptr_nxt  = 3'd0;
      w_pending_nxt = 8'd0;
      w_overrun_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|r_pending) begin
            w_out_idx_nxt = sel(r_pending, r_rr_ptr);
            w_state_nxt   = HOLD;
          end
        end
        HOLD: begin
          if (w_accept) begin
            w_rr_ptr_nxt = w_rr_ptr_acc;
            if (|w_rem) begin
              w_out_idx_nxt = sel(w_rem, w_rr_ptr_acc);
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= 8'd0;
      r_out_idx <= 3'd0;
      r_rr_ptr  <= 3'd0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_out_idx <= w_out_idx_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign out_idx   = r_out_idx;
  assign out_valid = (r_state == HOLD);
  assign pending   = r_pending;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_req_encoder_8to3.sv
// Directed bench for req_encoder_8to3: a round-robin instance driven from a vector
// table plus hand sequences, and a fixed-priority instance for the priority case.
module tb_req_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       clear;
  logic       out_ready;

  logic [2:0] rr_idx, fx_idx;
  logic       rr_valid, fx_valid;
  logic [7:0] rr_pend, fx_pend;
  logic       rr_ovr, fx_ovr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  req_encoder_8to3 #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .clear(clear),
    .out_idx(rr_idx), .out_valid(rr_valid), .out_ready(out_ready),
    .pending(rr_pend), .overrun(rr_ovr)
  );

  req_encoder_8to3 #(.ROUND_ROBIN(1'b0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .req(req), .clear(clear),
    .out_idx(fx_idx), .out_valid(fx_valid), .out_ready(out_ready),
    .pending(fx_pend), .overrun(fx_ovr)
  );

  typedef struct {
    logic [7:0] req;
    logic       clear;
    logic       rdy;
    logic [7:0] exp_pend;
    logic       exp_valid;
    logic [2:0] exp_idx;
    logic       exp_ovr;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 8'd0;
    clear     = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [7:0] r, input logic c, input logic rdy);
    req       = r;
    clear     = c;
    out_ready = rdy;
    tick();
  endtask

  task automatic chk_rr(input string name, input logic [7:0] p, input logic v,
                        input logic [2:0] idx, input logic o);
    chk({name, ".pending"}, rr_pend, p);
    chk({name, ".valid"}, {7'd0, rr_valid}, {7'd0, v});
    chk({name, ".overrun"}, {7'd0, rr_ovr}, {7'd0, o});
    if (v) chk({name, ".idx"}, {5'd0, rr_idx}, {5'd0, idx});
  endtask

  task automatic chk_fx(input string name, input logic [7:0] p, input logic v,
                        input logic [2:0] idx);
    chk({name, ".pending"}, fx_pend, p);
    chk({name, ".valid"}, {7'd0, fx_valid}, {7'd0, v});
    if (v) chk({name, ".idx"}, {5'd0, fx_idx}, {5'd0, idx});
  endtask

  initial begin
    // single request, rr_ptr advance probe, clear, round-robin order with wrap
    tbl[0]  = '{8'h08, 1'b0, 1'b1, 8'h08, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{8'h00, 1'b0, 1'b1, 8'h08, 1'b1, 3'd3, 1'b0};
    tbl[2]  = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[3]  = '{8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 3'd0, 1'b0};
    tbl[4]  = '{8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 3'd4, 1'b0};
    tbl[5]  = '{8'h00, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0};
    tbl[6]  = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[7]  = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[8]  = '{8'h92, 1'b0, 1'b1, 8'h92, 1'b0, 3'd0, 1'b0};
    tbl[9]  = '{8'h00, 1'b0, 1'b1, 8'h92, 1'b1, 3'd1, 1'b0};
    tbl[10] = '{8'h00, 1'b0, 1'b1, 8'h90, 1'b1, 3'd4, 1'b0};
    tbl[11] = '{8'h00, 1'b0, 1'b1, 8'h80, 1'b1, 3'd7, 1'b0};
    tbl[12] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[13] = '{8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 3'd0, 1'b0};
    tbl[14] = '{8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 3'd0, 1'b0};
    tbl[15] = '{8'h00, 1'b0, 1'b1, 8'h02, 1'b1, 3'd1, 1'b0};
    tbl[16] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};

    do_reset();
    chk_rr("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    chk("reset.idx", {5'd0, rr_idx}, 8'd0);

    for (int i = 0; i < 17; i++) begin
      req       = tbl[i].req;
      clear     = tbl[i].clear;
      out_ready = tbl[i].rdy;
      tick();
      chk_rr($sformatf("tbl%0d", i), tbl[i].exp_pend, tbl[i].exp_valid,
             tbl[i].exp_idx, tbl[i].exp_ovr);
    end

    // fixed priority: stalled grant of 5 holds while 0 arrives, then 5, 0, 7
    do_reset();
    drive(8'hA0, 1'b0, 1'b0); chk_fx("fx_load", 8'hA0, 1'b0, 3'd0);
    drive(8'h00, 1'b0, 1'b0); chk_fx("fx_g5", 8'hA0, 1'b1, 3'd5);
    drive(8'h01, 1'b0, 1'b0); chk_fx("fx_hold1", 8'hA1, 1'b1, 3'd5);
    drive(8'h00, 1'b0, 1'b0); chk_fx("fx_hold2", 8'hA1, 1'b1, 3'd5);
    drive(8'h00, 1'b0, 1'b1); chk_fx("fx_g0", 8'h81, 1'b1, 3'd0);
    drive(8'h00, 1'b0, 1'b1); chk_fx("fx_g7", 8'h80, 1'b1, 3'd7);
    drive(8'h00, 1'b0, 1'b1); chk_fx("fx_done", 8'h00, 1'b0, 3'd0);

    // backpressure overrun, then request coinciding with its own accept
    do_reset();
    drive(8'h04, 1'b0, 1'b0); chk_rr("ov_p1", 8'h04, 1'b0, 3'd0, 1'b0);
    drive(8'h04, 1'b0, 1'b0); chk_rr("ov_p2", 8'h04, 1'b1, 3'd2, 1'b1);
    drive(8'h00, 1'b0, 1'b1); chk_rr("ov_acc", 8'h00, 1'b0, 3'd0, 1'b1);
    drive(8'h00, 1'b0, 1'b1); chk_rr("ov_single", 8'h00, 1'b0, 3'd0, 1'b1);
    drive(8'h00, 1'b1, 1'b0); chk_rr("ov_clr", 8'h00, 1'b0, 3'd0, 1'b0);
    drive(8'h04, 1'b0, 1'b0); chk_rr("co_load", 8'h04, 1'b0, 3'd0, 1'b0);
    drive(8'h00, 1'b0, 1'b0); chk_rr("co_g2", 8'h04, 1'b1, 3'd2, 1'b0);
    drive(8'h04, 1'b0, 1'b1); chk_rr("co_acc", 8'h04, 1'b0, 3'd0, 1'b0);
    drive(8'h00, 1'b0, 1'b0); chk_rr("co_g2b", 8'h04, 1'b1, 3'd2, 1'b0);
    drive(8'h00, 1'b0, 1'b1); chk_rr("co_done", 8'h00, 1'b0, 3'd0, 1'b0);

    // clear beats simultaneous req and ready
    do_reset();
    drive(8'h40, 1'b0, 1'b0); chk_rr("cl_load", 8'h40, 1'b0, 3'd0, 1'b0);
    drive(8'h40, 1'b0, 1'b0); chk_rr("cl_g6", 8'h40, 1'b1, 3'd6, 1'b1);
    drive(8'hFF, 1'b1, 1'b1); chk_rr("cl_clr", 8'h00, 1'b0, 3'd0, 1'b0);
    drive(8'h00, 1'b0, 1'b1); chk_rr("cl_nogrant", 8'h00, 1'b0, 3'd0, 1'b0);

    // asynchronous reset between edges while holding a grant
    do_reset();
    drive(8'h20, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0); chk_rr("ar_g5", 8'h20, 1'b1, 3'd5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_rr("ar_async", 8'h00, 1'b0, 3'd0, 1'b0);
    chk("ar_async.idx", {5'd0, rr_idx}, 8'd0);
    tick();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
